// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream_demux slice.
//   N_OUT_MIN / N_OUT_MAX : legal range for the number of demux outputs.
//   state_t               : packet-tracking FSM states.
package stream_demux_pkg;

    localparam int unsigned N_OUT_MIN = 2;
    localparam int unsigned N_OUT_MAX = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUTE = 2'd1,
        S_DROP  = 2'd2
    } state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry valid/ready register stage used for each demux output.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : write ld_data/ld_last into the stage this cycle
//   ld_data, ld_last    : beat to be stored
//   out_ready           : downstream consumer ready
//   out_valid, out_data,
//   out_last            : registered beat presented downstream
//   can_load            : stage is empty or is being drained this cycle
module demux_slot #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              can_load
);

    assign can_load = !out_valid || out_ready;

    // A load in the same cycle as a drain replaces the old beat and keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_last  <= ld_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1-to-N stream demultiplexer.
// The destination (in_sel) is sampled on the first beat of a packet and locked
// until the last beat; packets with an out-of-range select are swallowed and
// flagged on err_sel. Each output has its own one-entry register stage, so a
// stalled output never blocks the others from draining.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_data/in_sel/in_last/in_valid: input stream, in_ready back-pressure
//   out_data/out_last/out_valid    : per-output streams (output k at [k*DATA_W +: DATA_W])
//   out_ready                      : per-output ready
//   err_sel                        : one-cycle pulse per packet with illegal select
//   busy                           : a packet is in progress
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    err_sel,
    output logic                    busy
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   tgt;
    logic               sel_legal;
    logic               tgt_can_load;
    logic               route_beat;
    logic               accept;
    logic [N_OUT-1:0]   load;
    logic [N_OUT-1:0]   can_load;

    // Extra bit so N_OUT itself is representable when N_OUT is a power of two.
    assign sel_legal = ({1'b0, in_sel} < (SEL_W+1)'(N_OUT));
    assign tgt       = (state_q == S_IDLE) ? in_sel : sel_q;
    assign busy      = (state_q != S_IDLE);

    // Decoded lookup instead of can_load[tgt] so an illegal tgt never indexes out of range.
    always_comb begin
        tgt_can_load = 1'b0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (tgt == SEL_W'(k)) begin
                tgt_can_load = can_load[k];
            end
        end
    end

    always_comb begin
        in_ready   = 1'b1;
        route_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                route_beat = sel_legal;
                in_ready   = sel_legal ? tgt_can_load : 1'b1;
            end
            S_ROUTE: begin
                route_beat = 1'b1;
                in_ready   = tgt_can_load;
            end
            default: begin
                route_beat = 1'b0;
                in_ready   = 1'b1;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        load = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            load[k] = accept && route_beat && (tgt == SEL_W'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    if (!in_last) begin
                        state_d = sel_legal ? S_ROUTE : S_DROP;
                    end
                end
                default: begin
                    if (in_last) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            err_sel <= 1'b0;
        end else begin
            state_q <= state_d;
            err_sel <= accept && (state_q == S_IDLE) && !sel_legal;
            if (accept && (state_q == S_IDLE) && sel_legal) begin
                sel_q <= in_sel;
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .ld_data   (in_data),
            .ld_last   (in_last),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .out_last  (out_last[k]),
            .can_load  (can_load[k])
        );
    end

endmodule
